// File: rtl/sad_search_engine.sv
// Sequential SAD motion-estimation engine: accumulates the SAD of each MxM candidate and keeps the best vector.
// Optional SAD_EARLY_TERM_EN: freezes candidates once they cannot win and exposes skip_cnt.
module sad_search_engine #(
  parameter  int PIX_W = 8,
  parameter  int M     = 16,
  parameter  int LANES = 4,
  parameter  int VEC_W = 6,
  localparam int SAD_W = PIX_W + $clog2(M*M)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*PIX_W-1:0]  cur_pix,
  input  logic [LANES*PIX_W-1:0]  ref_pix,
  input  logic signed [VEC_W-1:0] cand_mv_x,
  input  logic signed [VEC_W-1:0] cand_mv_y,
  input  logic                    cand_last,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [SAD_W-1:0]        best_sad,
  output logic signed [VEC_W-1:0] best_mv_x,
  output logic signed [VEC_W-1:0] best_mv_y,
`ifdef SAD_EARLY_TERM_EN
  output logic [15:0]             skip_cnt,
`endif
  output logic                    busy
);

  localparam int BEATS = (M * M) / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ACC, CMP, HOLD} state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        beat_q;
  logic [SAD_W-1:0]        acc_q, acc_d, lane_sum;
  logic [SAD_W-1:0]        min_sad_q, best_sad_q;
  logic signed [VEC_W-1:0] mv_x_q, mv_y_q, min_mv_x_q, min_mv_y_q;
  logic signed [VEC_W-1:0] best_mv_x_q, best_mv_y_q;
  logic                    last_q, in_ready_q, res_valid_q, busy_q;
  logic                    better;
  logic signed [PIX_W:0]   diff;
  logic [PIX_W:0]          mag;
`ifdef SAD_EARLY_TERM_EN
  logic                    term_q;
  logic [15:0]             skip_q;
`endif

  always_comb begin
    // NOTE: every combinational variable gets a default before any branch or loop so no latch is inferred.
    lane_sum = '0;
    diff     = '0;
    mag      = '0;
    for (int l = 0; l < LANES; l++) begin
      diff     = $signed({1'b0, cur_pix[l*PIX_W +: PIX_W]}) - $signed({1'b0, ref_pix[l*PIX_W +: PIX_W]});
      mag      = diff[PIX_W] ? -diff : diff;
      lane_sum = lane_sum + SAD_W'(mag);
    end
    better = (acc_q < min_sad_q);
`ifdef SAD_EARLY_TERM_EN
    // A candidate already at or above the running minimum can never win; stop adding to it.
    acc_d = better ? acc_q + lane_sum : acc_q;
`else
    acc_d = acc_q + lane_sum;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      acc_q       <= '0;
      min_sad_q   <= '1;
      mv_x_q      <= '0;
      mv_y_q      <= '0;
      min_mv_x_q  <= '0;
      min_mv_y_q  <= '0;
      best_sad_q  <= '0;
      best_mv_x_q <= '0;
      best_mv_y_q <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SAD_EARLY_TERM_EN
      term_q      <= 1'b0;
      skip_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            min_sad_q  <= '1;
            acc_q      <= '0;
            beat_q     <= '0;
            state_q    <= ACC;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
`ifdef SAD_EARLY_TERM_EN
            term_q     <= 1'b0;
            skip_q     <= '0;
`endif
          end
        end
        ACC: begin
          if (in_valid) begin
            if (beat_q == '0) begin
              mv_x_q <= cand_mv_x;
              mv_y_q <= cand_mv_y;
              last_q <= cand_last;
            end
            acc_q <= acc_d;
`ifdef SAD_EARLY_TERM_EN
            if (!better && !term_q) begin
              term_q <= 1'b1;
              if (skip_q != 16'hFFFF) skip_q <= skip_q + 16'd1;
            end
`endif
            if (beat_q == LAST_BEAT) begin
              beat_q     <= '0;
              state_q    <= CMP;
              in_ready_q <= 1'b0;
            end else begin
              beat_q <= beat_q + CNT_W'(1);
            end
          end
        end
        CMP: begin
          if (better) begin
            min_sad_q  <= acc_q;
            min_mv_x_q <= mv_x_q;
            min_mv_y_q <= mv_y_q;
          end
          acc_q  <= '0;
          beat_q <= '0;
`ifdef SAD_EARLY_TERM_EN
          term_q <= 1'b0;
`endif
          if (last_q) begin
            // Publish the final minimum directly so best_* only change when a result is presented.
            best_sad_q  <= better ? acc_q  : min_sad_q;
            best_mv_x_q <= better ? mv_x_q : min_mv_x_q;
            best_mv_y_q <= better ? mv_y_q : min_mv_y_q;
            res_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= ACC;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign best_sad  = best_sad_q;
  assign best_mv_x = best_mv_x_q;
  assign best_mv_y = best_mv_y_q;
  assign busy      = busy_q;
`ifdef SAD_EARLY_TERM_EN
  assign skip_cnt  = skip_q;
`endif

endmodule

// File: tb/tb_sad_search_engine.sv
// Scoreboard bench for sad_search_engine: a small M=4 instance for search behaviour and a default instance for range.
module tb_sad_search_engine;

  localparam int PIX_W = 8;
  localparam int M     = 4;
  localparam int LANES = 4;
  localparam int VEC_W = 6;
  localparam int SAD_W = PIX_W + $clog2(M*M);
  localparam int BEATS = M * M / LANES;
  localparam int B_SAD_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic                   start, in_valid, in_ready, cand_last, res_valid, res_ready, busy;
  logic [LANES*PIX_W-1:0] cur_pix, ref_pix;
  logic [VEC_W-1:0]       cand_mv_x, cand_mv_y, best_mv_x, best_mv_y;
  logic [SAD_W-1:0]       best_sad;

  logic                   b_start, b_in_valid, b_in_ready, b_cand_last, b_res_valid, b_res_ready, b_busy;
  logic [31:0]            b_cur_pix, b_ref_pix;
  logic [5:0]             b_mv_x, b_mv_y, b_best_mv_x, b_best_mv_y;
  logic [B_SAD_W-1:0]     b_best_sad;

`ifdef SAD_EARLY_TERM_EN
  logic [15:0] skip_cnt, b_skip_cnt;
`endif

  sad_search_engine #(.PIX_W(PIX_W), .M(M), .LANES(LANES), .VEC_W(VEC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .cur_pix(cur_pix), .ref_pix(ref_pix), .cand_mv_x(cand_mv_x), .cand_mv_y(cand_mv_y),
    .cand_last(cand_last), .res_valid(res_valid), .res_ready(res_ready), .best_sad(best_sad),
    .best_mv_x(best_mv_x), .best_mv_y(best_mv_y),
`ifdef SAD_EARLY_TERM_EN
    .skip_cnt(skip_cnt),
`endif
    .busy(busy)
  );

  sad_search_engine dut_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .cur_pix(b_cur_pix), .ref_pix(b_ref_pix), .cand_mv_x(b_mv_x), .cand_mv_y(b_mv_y),
    .cand_last(b_cand_last), .res_valid(b_res_valid), .res_ready(b_res_ready), .best_sad(b_best_sad),
    .best_mv_x(b_best_mv_x), .best_mv_y(b_best_mv_y),
`ifdef SAD_EARLY_TERM_EN
    .skip_cnt(b_skip_cnt),
`endif
    .busy(b_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sad;
    int mvx;
    int mvy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   tgt[8], mx[8], my[8];

  task automatic check(string tag, longint obs, longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Result monitor: compare each handshaken result against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("best_sad", best_sad, e.sad);
        check("best_mv_x", $signed(best_mv_x), e.mvx);
        check("best_mv_y", $signed(best_mv_y), e.mvy);
      end
    end
  end

  // Drives one candidate; pixel pairs differ by a spread of target so the model SAD is computed from the pixels.
  task automatic send_cand(input int target, input int mvx, input int mvy, input bit last, input bit thr,
                           input int cfix, input int rfix, output int sad);
    logic [LANES*PIX_W-1:0] cw, rw;
    int p, d, cv, rv;
    bit ok;
    sad = 0;
    for (int b = 0; b < BEATS; b++) begin
      for (int l = 0; l < LANES; l++) begin
        p = b * LANES + l;
        d = target / (M * M) + ((p < target % (M * M)) ? 1 : 0);
        if (cfix >= 0) begin
          cv = cfix;
          rv = rfix;
        end else begin
          rv = 128;
          cv = ($urandom_range(0, 1) == 1) ? 128 + d : 128 - d;
        end
        cw[l*PIX_W +: PIX_W] = PIX_W'(cv);
        rw[l*PIX_W +: PIX_W] = PIX_W'(rv);
        sad += (cv > rv) ? cv - rv : rv - cv;
      end
      if (thr && b > 0) begin
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
      end
      cur_pix  = cw;
      ref_pix  = rw;
      in_valid = 1'b1;
      if (b == 0) begin
        cand_mv_x = VEC_W'(mvx);
        cand_mv_y = VEC_W'(mvy);
        cand_last = last;
      end else begin
        cand_mv_x = VEC_W'($urandom);
        cand_mv_y = VEC_W'($urandom);
        cand_last = !last;
      end
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk); #1;
      end
      if (!ok) check("beat_accept_timeout", 0, 1);
    end
    in_valid  = 1'b0;
    cand_last = 1'b0;
  endtask

  task automatic run_search(input int n, input bit thr, input int cfix, input int rfix,
                            input int hold, input bit start_in_hold);
    int   s, best, bx, by;
    exp_t e;
    best = -1;
    bx = 0;
    by = 0;
    res_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", busy, 1);
    for (int c = 0; c < n; c++) begin
      send_cand(tgt[c], mx[c], my[c], (c == n - 1), thr, cfix, rfix, s);
      check("cmp_bubble_in_ready", in_ready, 0);
      if (best < 0 || s < best) begin
        best = s;
        bx = mx[c];
        by = my[c];
      end
    end
    e.sad = best;
    e.mvx = bx;
    e.mvy = by;
    exp_q.push_back(e);
    check("lat_edge1_res_valid", res_valid, 0);
    @(posedge clk); #1;
    check("lat_edge2_res_valid", res_valid, 1);
    check("hold_in_ready", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      check("hold_res_valid", res_valid, 1);
      check("hold_best_sad", best_sad, best);
      check("hold_best_mv_x", $signed(best_mv_x), bx);
      check("hold_in_ready", in_ready, 0);
      check("hold_busy", busy, 1);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    start     = start_in_hold;
    @(posedge clk); #1;
    res_ready = 1'b0;
    start     = 1'b0;
    check("post_hs_res_valid", res_valid, 0);
    check("post_hs_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    int beats;
    start = 0; in_valid = 0; cand_last = 0; res_ready = 0;
    cur_pix = '0; ref_pix = '0; cand_mv_x = '0; cand_mv_y = '0;
    b_start = 0; b_in_valid = 0; b_cand_last = 0; b_res_ready = 0;
    b_cur_pix = '0; b_ref_pix = '0; b_mv_x = '0; b_mv_y = '0;

    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_best_sad", best_sad, 0);
    check("rst_best_mv_x", best_mv_x, 0);
    check("rst_busy", busy, 0);
    check("rst_big_best_sad", b_best_sad, 0);
`ifdef SAD_EARLY_TERM_EN
    check("rst_skip_cnt", skip_cnt, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Beats offered without a start must be ignored.
    in_valid = 1'b1;
    cur_pix  = $urandom;
    ref_pix  = $urandom;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_in_ready", in_ready, 0);
      check("idle_busy", busy, 0);
    end
    in_valid = 1'b0;

    tgt[0] = 48; mx[0] = 2; my[0] = -1;
    run_search(1, 0, 10, 7, 0, 0);

    tgt[0] = 100; mx[0] = 0;  my[0] = 0;
    tgt[1] = 40;  mx[1] = 1;  my[1] = 1;
    tgt[2] = 40;  mx[2] = -3; my[2] = 2;
    run_search(3, 0, -1, -1, 0, 0);
    run_search(3, 1, -1, -1, 5, 0);

    // Reset two beats into a candidate: everything clears at once, nothing is emitted.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cur_pix = $urandom; ref_pix = $urandom; cand_last = 1'b1; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_best_sad", best_sad, 0);
    check("midrst_best_mv_x", best_mv_x, 0);
    check("midrst_best_mv_y", best_mv_y, 0);
    check("midrst_busy", busy, 0);
    in_valid = 1'b0; cand_last = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    tgt[0] = 48; mx[0] = 5; my[0] = -7;
    run_search(1, 0, -1, -1, 1, 1);

    tgt[0] = 20;  mx[0] = 3;  my[0] = 3;
    tgt[1] = 200; mx[1] = -2; my[1] = 1;
    run_search(2, 0, -1, -1, 0, 0);
`ifdef SAD_EARLY_TERM_EN
    check("skip_cnt", skip_cnt, 1);
`endif

    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        tgt[c] = $urandom_range(0, 400);
        mx[c]  = $urandom_range(0, 63) - 32;
        my[c]  = $urandom_range(0, 63) - 32;
      end
      run_search(3, (r % 2) == 1, -1, -1, r, 0);
    end

    // Default-parameter instance: worst-case SAD must fit without wrapping.
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    b_cur_pix = '1; b_ref_pix = '0; b_cand_last = 1'b1; b_in_valid = 1'b1;
    beats = 0;
    for (int t = 0; t < 200 && beats < 64; t++) begin
      @(negedge clk);
      if (b_in_ready) beats++;
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    check("big_beats_accepted", beats, 64);
    ok = 1'b0;
    for (int t = 0; t < 10 && !ok; t++) begin
      @(negedge clk);
      ok = b_res_valid;
      if (!ok) begin
        @(posedge clk); #1;
      end
    end
    check("big_res_valid", ok, 1);
    check("big_best_sad", b_best_sad, 65280);
    b_res_ready = 1'b1;
    @(posedge clk); #1;
    b_res_ready = 1'b0;
    check("big_post_hs_busy", b_busy, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sad_search_engine.md
Name: sad_search_engine

Overview:
- Sequential, parametrised sum-of-absolute-differences (SAD) motion-estimation engine.
- Streams current-block and reference pixels LANES per beat and accumulates the SAD of each MxM candidate block.
- Tracks the minimum SAD and its motion vector across a search of any number of candidates, then presents the best result on a valid/ready channel.
- Sits between the search-window fetch unit (pixel source) and the motion-vector selector (result sink).

Parameters:
- PIX_W, 8: pixel bit width (unsigned).
- M, 16: block edge; each candidate is M*M pixel pairs.
- LANES, 4: pixel pairs per input beat; M*M must be divisible by LANES.
- VEC_W, 6: signed motion-vector component width.
- SAD_W, PIX_W+clog2(M*M): accumulator/result width (derived, localparam).

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: pulse that begins a new search; honoured only in IDLE.
- in_valid, input, 1: pixel beat valid.
- in_ready, output, 1: engine accepts beat.
- cur_pix, input, LANES*PIX_W: current-block pixels; lane 0 in LSBs.
- ref_pix, input, LANES*PIX_W: candidate pixels, same lane order.
- cand_mv_x, input, VEC_W: signed candidate vector x; sampled on the first beat of each candidate.
- cand_mv_y, input, VEC_W: signed candidate vector y; sampled on the first beat of each candidate.
- cand_last, input, 1: marks final candidate of the search; sampled on the first beat of each candidate.
- res_valid, output, 1: best result valid.
- res_ready, input, 1: sink accepts result.
- best_sad, output, SAD_W: minimum SAD of the search.
- best_mv_x, output, VEC_W: vector x of the minimum.
- best_mv_y, output, VEC_W: vector y of the minimum.
- busy, output, 1: high whenever the state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; beat counter and accumulator clear.
  - in_ready=0, res_valid=0, best_sad=0, best_mv_x/y=0, busy=0.
  - Reset mid-candidate or mid-HOLD abandons the search; no partial result is emitted.
- BEATS = M*M/LANES. A beat is accepted when in_valid && in_ready.
- Per beat: add the sum over lanes of |cur-ref| to acc. Differences are computed at PIX_W+1 signed; the lane sum is zero-extended to SAD_W.
  - Max SAD = (2^PIX_W-1)*M*M, which fits SAD_W with no overflow and no saturation.
- FSM states:
  - IDLE: in_ready=0. On start: best_sad := all-ones (internal), acc := 0, beat_cnt := 0, go to ACC.
  - ACC: in_ready=1.
    - The first beat of a candidate (beat_cnt==0) latches cand_mv_x/y and cand_last.
    - Each accepted beat increments beat_cnt.
    - The beat accepted with beat_cnt==BEATS-1 moves to CMP; acc then includes that beat.
  - CMP: one cycle, in_ready=0.
    - If acc < best_sad (strict), load best_sad/best_mv from acc and the latched vector. Ties keep the earlier candidate.
    - If latched last: go to HOLD. Otherwise clear acc and beat_cnt and return to ACC.
  - HOLD: res_valid=1, in_ready=0; outputs stable until res_ready. On res_valid && res_ready, go to IDLE and drop res_valid.
- Latency: res_valid rises on the 2nd rising edge after the final beat of the last candidate is accepted.
- Throughput: one beat per cycle within a candidate, plus one bubble cycle (CMP) between candidates.
- Edge cases:
  - in_valid with no start is ignored in IDLE.
  - start outside IDLE is ignored.
  - start and res_ready in the same HOLD cycle: the result completes, start is dropped.
  - Outside HOLD, best_* hold their last values; outputs are visible but qualified only by res_valid.
  - A single-candidate search (cand_last on the first candidate) is legal.

Optional Feature:
- Macro SAD_EARLY_TERM_EN.
- When defined:
  - Adds output skip_cnt (16 bits, reset 0; cleared on start).
  - In ACC, once acc >= best_sad, accumulation freezes for the remaining beats of that candidate (beats are still consumed).
  - skip_cnt increments once per terminated candidate, saturating at 0xFFFF.
  - best_sad and best_mv results are identical to the build without the macro.
- When undefined: no skip_cnt port; every beat accumulates.

Test Plan:
- M=4, LANES=4, one candidate: all cur=10, ref=7, mv=(2,-1), cand_last=1 -> best_sad=48, best_mv=(2,-1); res_valid 2 edges after 4th beat.
- M=4, LANES=4: candidate SADs 100, 40, 40 with mv (0,0), (1,1), (-3,2) -> best_sad=40, best_mv=(1,1) (tie keeps earlier).
- Backpressure: in_valid toggled every other cycle; res_ready low 5 cycles -> same SAD as unthrottled; res_valid and best_* stable for 5 cycles; in_ready=0 throughout HOLD; busy=1 until handshake.
- Defaults (M=16, LANES=4): cur=255, ref=0 for all 64 beats -> best_sad=65280, no wrap.
- rst_n asserted after 2 beats of a candidate -> all outputs 0 immediately; a following clean search with SAD 48 returns 48.
- With SAD_EARLY_TERM_EN, M=4: candidate SADs 20 then 200, last on the second -> best_sad=20, skip_cnt=1. The same stimulus without the macro gives best_sad=20.
